// File: rtl/bus_dump_serializer_pkg.sv
// Shared debug-unit definitions: dump FSM state encoding, UART byte width
// default and a ceiling-log2 helper used to size counters and offsets.
package bus_dump_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int UART_BUS_SIZE_DEF = 8;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_dump_serializer_if.sv
// Snapshot-in / UART-out signal bundle of the dump serializer.
// master = debug unit side (drives start/data/full), slave = serializer.
import bus_dump_serializer_pkg::*;

interface bus_dump_serializer_if #(
    parameter int DATA_BUS_SIZE = 1024,
    parameter int UART_BUS_SIZE = UART_BUS_SIZE_DEF
);
    logic                     i_start;
    logic [DATA_BUS_SIZE-1:0] i_data;
    logic                     i_uart_full;
    logic                     o_uart_wr;
    logic [UART_BUS_SIZE-1:0] o_uart_data;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        output i_start, i_data, i_uart_full,
        input  o_uart_wr, o_uart_data, o_busy, o_done
    );

    modport slave (
        input  i_start, i_data, i_uart_full,
        output o_uart_wr, o_uart_data, o_busy, o_done
    );
endinterface

// File: rtl/bus_dump_serializer.sv
// Captures a wide snapshot bus on i_start and streams it byte by byte into
// the UART TX FIFO, word 0 first, most-significant byte of each word first.
//
// state | meaning
// IDLE  | waiting for i_start; capture snapshot, clear byte counter
// SEND  | write current byte when FIFO not full, otherwise hold
// GAP   | idle cycle so the FIFO full flag can settle; advance or finish
// DONE  | one-cycle o_done pulse, busy drops, back to IDLE
module bus_dump_serializer
    import bus_dump_serializer_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int WORD_COUNT    = 32,
    parameter int UART_BUS_SIZE = UART_BUS_SIZE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    bus_dump_serializer_if.slave  bus
);

    localparam int DATA_BUS_SIZE  = WORD_SIZE * WORD_COUNT;
    localparam int BYTES_PER_WORD = WORD_SIZE / UART_BUS_SIZE;
    localparam int TOTAL_BYTES    = WORD_COUNT * BYTES_PER_WORD;
    localparam int CNT_BITS       = clog2(TOTAL_BYTES + 1);
    localparam int OFF_BITS       = clog2(DATA_BUS_SIZE);

    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(TOTAL_BYTES - 1);

    state_e                   state_q;
    logic [DATA_BUS_SIZE-1:0] snap_q;
    logic [CNT_BITS-1:0]      cnt_q;
    logic                     wr_q;
    logic [UART_BUS_SIZE-1:0] data_q;
    logic                     busy_q;
    logic                     done_q;

    logic [OFF_BITS-1:0]      sel_off;
    logic [UART_BUS_SIZE-1:0] sel_byte;

    // Bit offset of byte n: word n/BPW, lane counted down from the MSB end.
    function automatic int byte_offset(input int n);
        int word_idx;
        int lane_idx;
        word_idx = n / BYTES_PER_WORD;
        lane_idx = BYTES_PER_WORD - 1 - (n % BYTES_PER_WORD);
        return (word_idx * BYTES_PER_WORD + lane_idx) * UART_BUS_SIZE;
    endfunction

    // Select the byte addressed by the counter out of the captured snapshot.
    always_comb begin
        sel_off  = OFF_BITS'(byte_offset(int'(cnt_q)));
        sel_byte = snap_q[sel_off +: UART_BUS_SIZE];
    end

    // Dump sequencer with all outputs registered; wr/done default low so
    // each is a single-cycle strobe.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        snap_q  <= bus.i_data;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!bus.i_uart_full) begin
                        wr_q    <= 1'b1;
                        data_q  <= sel_byte;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == LAST_BYTE) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_BITS'(1);
                        state_q <= ST_SEND;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_uart_wr   = wr_q;
    assign bus.o_uart_data = data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_bus_dump_serializer.sv
// Bench for bus_dump_serializer: a 2-word instance for directed and random
// dumps, and a default 32x32 instance for a full-size dump.
module tb_bus_dump_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_dump_serializer_if #(.DATA_BUS_SIZE(64),   .UART_BUS_SIZE(8)) s_if ();
    bus_dump_serializer_if #(.DATA_BUS_SIZE(1024), .UART_BUS_SIZE(8)) l_if ();

    bus_dump_serializer #(.WORD_SIZE(32), .WORD_COUNT(2), .UART_BUS_SIZE(8)) u_small (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (s_if.slave)
    );

    bus_dump_serializer u_large (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (l_if.slave)
    );

    // Observed traffic, sampled on the falling edge.
    logic [7:0] s_got[$];
    int         s_gotcyc[$];
    int         s_done_n = 0;
    int         s_done_cyc = 0;
    int         s_dbl = 0;
    logic       s_prev = 1'b0;
    logic [7:0] l_got[$];
    int         l_done_n = 0;
    int         l_done_cyc = 0;
    int         l_dbl = 0;
    logic       l_prev = 1'b0;

    always @(negedge clk) begin
        if (s_if.o_uart_wr === 1'b1) begin
            s_got.push_back(s_if.o_uart_data);
            s_gotcyc.push_back(cyc);
            if (s_prev) s_dbl++;
        end
        s_prev = (s_if.o_uart_wr === 1'b1);
        if (s_if.o_done === 1'b1) begin
            s_done_n++;
            s_done_cyc = cyc;
        end
        if (l_if.o_uart_wr === 1'b1) begin
            l_got.push_back(l_if.o_uart_data);
            if (l_prev) l_dbl++;
        end
        l_prev = (l_if.o_uart_wr === 1'b1);
        if (l_if.o_done === 1'b1) begin
            l_done_n++;
            l_done_cyc = cyc;
        end
    end

    // Reference model: expected byte stream from word list, word 0 first,
    // each word most-significant byte first.
    logic [7:0] exp_q[$];

    task automatic make_exp(input logic [1023:0] d, input int wc);
        logic [1023:0] sh;
        logic [31:0]   wv;
        exp_q.delete();
        for (int w = 0; w < wc; w++) begin
            sh = d >> (w * 32);
            wv = sh[31:0];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(wv[31:24]);
                wv = wv << 8;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        logic [31:0] obs;
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            obs = (i < got.size()) ? {24'h0, got[i]} : 'x;
            chk($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp[i]});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_small();
        s_got.delete();
        s_gotcyc.delete();
        s_done_n = 0;
        s_if.i_uart_full = 1'b0;
    endtask

    // t0 marks the clock edge that launches i_start; the following edge captures.
    task automatic start_small(input logic [63:0] d);
        s_if.i_data  = d;
        s_if.i_start = 1'b1;
        t0 = cyc;
        tick();
        s_if.i_start = 1'b0;
    endtask

    task automatic wait_small_done(input string tag, input int bound);
        int i;
        i = 0;
        while (i < bound && s_done_n == 0) begin
            tick();
            i++;
        end
        chk({tag, "_done_seen"}, (s_done_n != 0), 1);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int bound);
        int i;
        i = 0;
        while (i < bound && s_got.size() < n) begin
            tick();
            i++;
        end
        chk({tag, "_bytes_reached"}, (s_got.size() >= n), 1);
    endtask

    logic [63:0]   d1;
    logic [63:0]   dr;
    logic [1023:0] ld;
    logic [31:0]   wv;
    int            c;

    initial begin
        s_if.i_start = 1'b0; s_if.i_data = '0; s_if.i_uart_full = 1'b0;
        l_if.i_start = 1'b0; l_if.i_data = '0; l_if.i_uart_full = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_s_wr",   s_if.o_uart_wr,   0);
        chk("rst_s_data", s_if.o_uart_data, 0);
        chk("rst_s_busy", s_if.o_busy,      0);
        chk("rst_s_done", s_if.o_done,      0);
        chk("rst_l_wr",   l_if.o_uart_wr,   0);
        chk("rst_l_data", l_if.o_uart_data, 0);
        chk("rst_l_busy", l_if.o_busy,      0);
        chk("rst_l_done", l_if.o_done,      0);
        rst = 1'b0;
        tick();

        // Plain dump, no back-pressure.
        d1 = {32'hAABBCCDD, 32'h11223344};
        make_exp(1024'(d1), 2);
        clear_small();
        start_small(d1);
        chk("t1_busy", s_if.o_busy, 1);
        wait_small_done("t1", 100);
        tick(); tick(); tick();
        chk_stream("t1", s_got, exp_q);
        chk("t1_first_byte", (s_got.size() > 0) ? s_got[0] : 8'hxx, 8'h11);
        chk("t1_last_byte",  (s_got.size() > 7) ? s_got[7] : 8'hxx, 8'hDD);
        chk("t1_first_lat",  (s_gotcyc.size() > 0) ? s_gotcyc[0] - t0 : -1, 2);
        if (s_gotcyc.size() == 8)
            for (int i = 1; i < 8; i++)
                chk($sformatf("t1_spacing%0d", i), s_gotcyc[i] - s_gotcyc[i-1], 2);
        chk("t1_done_lat", s_done_cyc - t0, 18);
        chk("t1_done_once", s_done_n, 1);
        chk("t1_busy_end", s_if.o_busy, 0);

        // Snapshot isolation: bus cleared right after capture.
        clear_small();
        start_small(d1);
        s_if.i_data = '0;
        wait_small_done("t2", 100);
        tick(); tick(); tick();
        chk_stream("t2", s_got, exp_q);

        // Back-pressure held for 10 cycles before byte 3.
        clear_small();
        start_small(d1);
        wait_bytes("t3", 3, 50);
        s_if.i_uart_full = 1'b1;
        repeat (10) tick();
        chk("t3_no_strobe_full", s_got.size(), 3);
        s_if.i_uart_full = 1'b0;
        c = cyc;
        tick();
        chk("t3_resume_lat", (s_gotcyc.size() > 3) ? s_gotcyc[3] - c : -1, 1);
        chk("t3_resume_byte", (s_got.size() > 3) ? s_got[3] : 8'hxx, 8'h44);
        wait_small_done("t3", 100);
        tick(); tick(); tick();
        chk_stream("t3", s_got, exp_q);
        chk("t3_done_once", s_done_n, 1);

        // Second start while busy is ignored.
        clear_small();
        start_small(d1);
        wait_bytes("t4", 2, 50);
        s_if.i_start = 1'b1;
        s_if.i_data  = {$urandom, $urandom};
        tick();
        s_if.i_start = 1'b0;
        wait_small_done("t4", 100);
        repeat (5) tick();
        chk_stream("t4", s_got, exp_q);
        chk("t4_done_once", s_done_n, 1);
        chk("t4_idle_after", s_if.o_busy, 0);

        // Reset mid-dump while a strobe is high.
        clear_small();
        start_small(d1);
        wait_bytes("t5", 4, 50);
        rst = 1'b1;
        #1;
        chk("t5_async_wr",   s_if.o_uart_wr,   0);
        chk("t5_async_data", s_if.o_uart_data, 0);
        chk("t5_async_busy", s_if.o_busy,      0);
        chk("t5_async_done", s_if.o_done,      0);
        tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("t5_no_more_bytes", s_got.size(), 4);
        chk("t5_no_done", s_done_n, 0);
        clear_small();
        dr = {32'h0, 32'hDEADBEEF};
        make_exp(1024'(dr), 2);
        start_small(dr);
        wait_small_done("t5b", 100);
        tick(); tick(); tick();
        chk_stream("t5b", s_got, exp_q);
        chk("t5b_first", (s_got.size() > 0) ? s_got[0] : 8'hxx, 8'hDE);

        // Random data with random FIFO back-pressure.
        for (int r = 0; r < 4; r++) begin
            dr = {$urandom, $urandom};
            make_exp(1024'(dr), 2);
            clear_small();
            start_small(dr);
            for (int i = 0; i < 400 && s_done_n == 0; i++) begin
                s_if.i_uart_full = ($urandom_range(0, 2) == 0);
                tick();
            end
            s_if.i_uart_full = 1'b0;
            chk($sformatf("rnd%0d_done_seen", r), (s_done_n != 0), 1);
            tick(); tick(); tick();
            chk_stream($sformatf("rnd%0d", r), s_got, exp_q);
            chk($sformatf("rnd%0d_done_once", r), s_done_n, 1);
        end

        // Full-size dump: byte n carries value n.
        ld = '0;
        for (int w = 0; w < 32; w++) begin
            wv = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            ld = ld | (1024'(wv) << (w * 32));
        end
        make_exp(ld, 32);
        l_got.delete();
        l_done_n = 0;
        l_if.i_data  = ld;
        l_if.i_start = 1'b1;
        t0 = cyc;
        tick();
        l_if.i_start = 1'b0;
        for (int i = 0; i < 400 && l_done_n == 0; i++) tick();
        chk("big_done_seen", (l_done_n != 0), 1);
        tick(); tick(); tick();
        chk_stream("big", l_got, exp_q);
        chk("big_byte5",   (l_got.size() > 5)   ? l_got[5]   : 8'hxx, 8'd5);
        chk("big_byte127", (l_got.size() > 127) ? l_got[127] : 8'hxx, 8'd127);
        chk("big_done_lat", l_done_cyc - t0, 258);
        chk("big_done_once", l_done_n, 1);

        chk("s_wr_never_back_to_back", s_dbl, 0);
        chk("l_wr_never_back_to_back", l_dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_dump_serializer.md
Name: bus_dump_serializer

Overview:
- Serializes a wide snapshot bus (register bank or data memory contents) into a byte stream for the UART TX FIFO.
- Sits between the MIPS core's content outputs and the UART write port. The debug unit instantiates it to return program state to the host.
- Captures the bus on a start pulse, then emits every byte under FIFO back-pressure and pulses done at the end.

Parameters:
- WORD_SIZE, 32, bits per word in the snapshot bus.
- WORD_COUNT, 32, number of words in the snapshot bus.
- UART_BUS_SIZE, 8, bits per byte sent to the UART. WORD_SIZE must be a multiple of UART_BUS_SIZE.
- Derived localparams:
  - DATA_BUS_SIZE = WORD_SIZE*WORD_COUNT
  - BYTES_PER_WORD = WORD_SIZE/UART_BUS_SIZE
  - TOTAL_BYTES = WORD_COUNT*BYTES_PER_WORD
  - CNT_BITS = clog2(TOTAL_BYTES+1)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle request to capture i_data and begin a dump
- i_data  in  DATA_BUS_SIZE  snapshot bus; word k is i_data[k*WORD_SIZE +: WORD_SIZE]
- i_uart_full  in  1  UART TX FIFO full
- o_uart_wr  out  1  one-cycle write strobe to the UART TX FIFO
- o_uart_data  out  UART_BUS_SIZE  byte presented with o_uart_wr
- o_busy  out  1  high from capture until done
- o_done  out  1  one-cycle pulse after the last byte is written

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; o_uart_wr=0, o_uart_data=0, o_busy=0, o_done=0; byte counter=0; snapshot register=0.
- All outputs are registered.
- States:
  - IDLE: o_busy=0. When i_start=1, latch i_data into the snapshot register, clear the counter, and go to SEND. o_busy=1 from the next cycle.
  - SEND: if i_uart_full=0, register o_uart_wr=1 and o_uart_data=selected byte, then go to GAP. If full, hold in SEND with o_uart_wr=0 for as long as full persists.
  - GAP: o_uart_wr=0. This mandatory idle cycle lets the FIFO full flag update. If counter==TOTAL_BYTES-1, go to DONE; else increment the counter and go to SEND.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 on the following cycle, return to IDLE.
- Byte order:
  - Word 0 first, ascending word index.
  - Within a word, most-significant byte first.
  - Byte n = snapshot word (n / BYTES_PER_WORD), byte lane (BYTES_PER_WORD-1 - n % BYTES_PER_WORD).
- Throughput: at most one byte per 2 cycles. With no back-pressure, a dump takes 2*TOTAL_BYTES+2 cycles from the i_start edge to o_done.
- Snapshot isolation: i_data changes after capture never affect emitted bytes.
- i_start while busy (any state except IDLE) is ignored; no restart and no re-capture.
- i_start in the same cycle as DONE is ignored. It is accepted only in IDLE.
- i_uart_full asserting while in GAP has no effect until SEND.
- o_uart_wr is never high in two consecutive cycles.
- o_uart_data holds its last value when o_uart_wr=0.
- Reset mid-dump aborts immediately:
  - no further strobes;
  - no o_done pulse;
  - the next i_start begins at byte 0.
- Counter width CNT_BITS; the counter never exceeds TOTAL_BYTES-1.

Decomposition:
- Shared debug package holds:
  - the state encoding (IDLE, SEND, GAP, DONE, 2 bits);
  - the UART_BUS_SIZE default;
  - a clog2 function reused across the debug logic.
- No sub-module: byte selection is an indexed part-select of the snapshot register. A separate mux module adds nothing.

Test Plan:
- WORD_COUNT=2, i_data={32'hAABBCCDD,32'h11223344}, start, full=0:
  - bytes 11,22,33,44,AA,BB,CC,DD on 8 strobes spaced 2 cycles apart;
  - o_done 18 cycles after start, exactly one pulse.
- Same setup, change i_data to all zeros one cycle after start -> identical byte stream (snapshot isolation).
- Hold i_uart_full=1 for 10 cycles starting before byte 3:
  - no strobe while full;
  - byte 3 (44) emitted on the first SEND cycle after full drops;
  - order and total count intact.
- Pulse i_start again during byte 2 -> ignored; exactly 8 bytes and one o_done.
- Assert i_reset after byte 4:
  - outputs go to 0 asynchronously;
  - no o_done;
  - a new start with i_data={32'h0,32'hDEADBEEF} emits DE,AD,BE,EF,00,00,00,00.
- Default parameters (32x32) with an incrementing pattern -> 128 bytes in the correct order, o_done after 258 cycles.
